// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the iterative restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OP   = 2'd1,
        S_END  = 2'd2
    } state_t;

    localparam int DATA_W_DEF = 32;

    // Field offsets inside the {remainder, quotient} result word.
    localparam int QUO_LSB = 0;

    function automatic int rem_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int iter_of(input int data_w, input int bpc);
        return data_w / bpc;
    endfunction

    // Counter width; never below one bit so the register always exists.
    function automatic int cnt_w(input int iter);
        return (iter > 1) ? $clog2(iter) : 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// subtract the divisor if it fits, report the quotient bit.
module div_step #(
    parameter int W = 32
) (
    input  logic [W:0]   rem_i,
    input  logic         bit_i,
    input  logic [W-1:0] dvs_i,
    output logic [W:0]   rem_o,
    output logic         q_o
);

    logic [W+1:0] sh;
    logic [W:0]   diff;

    // Shifted value is one bit wider than the remainder register so the compare never overflows.
    assign sh    = {rem_i, bit_i};
    assign q_o   = (sh >= {2'b00, dvs_i});
    assign diff  = sh[W:0] - {1'b0, dvs_i};
    assign rem_o = q_o ? diff : sh[W:0];

endmodule

// File: rtl/iter_divider.sv
// Iterative restoring divider, BITS_PER_CYCLE quotient bits per clock.
// Optional macro DIV_SIGNED_EN adds the sign_op input for two's-complement division.
module iter_divider
    import div_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     dividend,
    input  logic [DATA_W-1:0]     divisor,
`ifdef DIV_SIGNED_EN
    input  logic                  sign_op,
`endif
    output logic [2*DATA_W-1:0]   result,
    output logic                  out_valid,
    output logic                  stall
);

    localparam int W    = DATA_W;
    localparam int BPC  = BITS_PER_CYCLE;
    localparam int ITER = iter_of(DATA_W, BITS_PER_CYCLE);
    localparam int CW   = cnt_w(ITER);
    localparam int RLSB = rem_lsb(DATA_W);

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [W-1:0]      dq_q;      // dividend shifts out the top, quotient fills the bottom
    logic [W-1:0]      dvs_q;
    logic [W:0]        rem_q;
    logic              qneg_q;
    logic              rneg_q;
    logic [2*W-1:0]    res_q;
    logic              ov_q;

    // Operand preparation: magnitudes and sign fixup flags.
    logic              dvd_neg, dvs_neg;
    logic [W-1:0]      dvd_mag, dvs_mag;

`ifdef DIV_SIGNED_EN
    assign dvd_neg = sign_op & dividend[W-1];
    assign dvs_neg = sign_op & divisor[W-1];
`else
    assign dvd_neg = 1'b0;
    assign dvs_neg = 1'b0;
`endif
    assign dvd_mag = dvd_neg ? -dividend : dividend;
    assign dvs_mag = dvs_neg ? -divisor  : divisor;

    // Step chain, MSB of the remaining dividend first.
    logic [BPC:0][W:0] rem_c;
    logic [BPC-1:0]    qb;
    logic [W-1:0]      dq_d;
    logic [W-1:0]      quo_f, rem_f;

    assign rem_c[0] = rem_q;

    for (genvar i = 0; i < BPC; i++) begin : g_step
        div_step #(.W(W)) u_step (
            .rem_i (rem_c[i]),
            .bit_i (dq_q[W-1-i]),
            .dvs_i (dvs_q),
            .rem_o (rem_c[i+1]),
            .q_o   (qb[BPC-1-i])
        );
    end

    assign dq_d  = {dq_q[W-BPC-1:0], qb};
    assign quo_f = qneg_q ? -dq_d : dq_d;
    assign rem_f = rneg_q ? -rem_c[BPC][W-1:0] : rem_c[BPC][W-1:0];

    // Control FSM and datapath registers; result latched on the last iteration edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dq_q    <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            res_q   <= '0;
            ov_q    <= 1'b0;
        end else begin
            ov_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        state_q <= S_OP;
                        cnt_q   <= '0;
                        dq_q    <= dvd_mag;
                        dvs_q   <= dvs_mag;
                        rem_q   <= '0;
                        // Divide by zero keeps the all-ones quotient un-negated.
                        qneg_q  <= (dvd_neg ^ dvs_neg) & (divisor != '0);
                        rneg_q  <= dvd_neg;
                    end
                end
                S_OP: begin
                    dq_q  <= dq_d;
                    rem_q <= rem_c[BPC];
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(ITER - 1)) begin
                        state_q <= S_END;
                        res_q[RLSB +: W]    <= rem_f;
                        res_q[QUO_LSB +: W] <= quo_f;
                        ov_q                <= 1'b1;
                    end
                end
                S_END:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign result    = res_q;
    assign out_valid = ov_q;
    assign stall     = (state_q == S_OP) | ((state_q == S_IDLE) & in_valid);

endmodule
